// File: rtl/clz_scan_pkg.sv
// Shared types and width helpers for the multi-cycle leading-zero scanner.
package clz_scan_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_DATA_DEF  = 32;
  localparam int W_SLICE_DEF = 8;

  function automatic int n_slice(input int w_data, input int w_slice);
    return w_data / w_slice;
  endfunction

  function automatic int cnt_width(input int w_data);
    return $clog2(w_data) + 1;
  endfunction

  // An index register needs at least one bit even for a single-slice word.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/count_lead_zero.sv
// Recursive leading-zero counter for a power-of-two width; all-zero input
// saturates to W_IN-1, so callers must detect the zero case themselves.
module count_lead_zero #(
  parameter int W_IN = 8
) (
  input  logic [W_IN-1:0]         data,
  output logic [$clog2(W_IN)-1:0] cnt
);

  generate
    if (W_IN == 2) begin : g_leaf
      assign cnt = (data == 2'b00) ? 1'b1 : ~data[1];
    end else begin : g_node
      localparam int W_HALF = W_IN / 2;
      logic [$clog2(W_HALF)-1:0] cnt_hi;
      logic [$clog2(W_HALF)-1:0] cnt_lo;

      count_lead_zero #(.W_IN(W_HALF)) u_hi (
        .data (data[W_IN-1:W_HALF]),
        .cnt  (cnt_hi)
      );

      count_lead_zero #(.W_IN(W_HALF)) u_lo (
        .data (data[W_HALF-1:0]),
        .cnt  (cnt_lo)
      );

      assign cnt = (~|data[W_IN-1:W_HALF]) ? {1'b1, cnt_lo} : {1'b0, cnt_hi};
    end
  endgenerate

endmodule

// File: rtl/clz_scan_ctrl.sv
// Multi-cycle leading-zero counter: scans a wide word MSB-first one slice per cycle.
// Define CLZ_SCAN_NORM_EN to add the out_norm port (input left-justified by the count).
//
// state | meaning
// IDLE  | waiting for a request, in_ready high, last result held
// SCAN  | examining the top slice of the working register
// DONE  | result presented, waiting for out_ready
module clz_scan_ctrl
  import clz_scan_pkg::*;
#(
  parameter  int W_DATA  = W_DATA_DEF,
  parameter  int W_SLICE = W_SLICE_DEF,
  localparam int W_CNT   = cnt_width(W_DATA)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_DATA-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_CNT-1:0]  out_count,
  output logic              out_zero,
  output logic              busy
`ifdef CLZ_SCAN_NORM_EN
  ,
  output logic [W_DATA-1:0] out_norm
`endif
);

  localparam int N_SLICE = n_slice(W_DATA, W_SLICE);
  localparam int W_IDX   = idx_width(N_SLICE);
  localparam int W_CLZ   = $clog2(W_SLICE);

  localparam logic [W_IDX-1:0] IDX_LAST = W_IDX'(N_SLICE - 1);
  localparam logic [W_CNT-1:0] CNT_STEP = W_CNT'(W_SLICE);
  localparam logic [W_CNT-1:0] CNT_FULL = W_CNT'(W_DATA);

  state_t              state;
  state_t              state_nxt;
  logic [W_DATA-1:0]   work;
  logic [W_DATA-1:0]   work_fin;
  logic [W_CNT-1:0]    acc;
  logic [W_IDX-1:0]    idx;
  logic [W_SLICE-1:0]  slice;
  logic                slice_zero;
  logic [W_CLZ-1:0]    clz_slice;

  assign slice      = work[W_DATA-1 -: W_SLICE];
  // Zero slices come from the reduction, not the saturated core result.
  assign slice_zero = ~|slice;

  count_lead_zero #(.W_IN(W_SLICE)) u_clz (
    .data (slice),
    .cnt  (clz_slice)
  );

`ifdef CLZ_SCAN_NORM_EN
  assign work_fin = work << clz_slice;
  assign out_norm = work;
`else
  assign work_fin = work;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = SCAN;
      end
      SCAN: begin
        if (!slice_zero || (idx == IDX_LAST)) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work      <= '0;
      acc       <= '0;
      idx       <= '0;
      out_count <= '0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_data;
            acc  <= '0;
            idx  <= '0;
          end
        end
        SCAN: begin
          if (!slice_zero) begin
            out_count <= acc + W_CNT'(clz_slice);
            out_zero  <= 1'b0;
            work      <= work_fin;
          end else if (idx == IDX_LAST) begin
            out_count <= CNT_FULL;
            out_zero  <= 1'b1;
          end else begin
            acc  <= acc + CNT_STEP;
            work <= work << W_SLICE;
            idx  <= idx + W_IDX'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clz_scan_ctrl.sv
// Self-checking bench for clz_scan_ctrl (W_DATA=32, W_SLICE=8); honours CLZ_SCAN_NORM_EN.
module tb_clz_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [5:0]  out_count;
  logic        out_zero;
  logic        busy;
`ifdef CLZ_SCAN_NORM_EN
  logic [31:0] out_norm;
`endif

  always #5 clk = ~clk;

  clz_scan_ctrl #(.W_DATA(32), .W_SLICE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_zero  (out_zero),
    .busy      (busy)
`ifdef CLZ_SCAN_NORM_EN
    ,
    .out_norm  (out_norm)
`endif
  );

  typedef struct {
    logic [31:0] data;
    int          count;
    bit          zero;
    logic [31:0] norm;
    int          lat;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[8];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] d);
    vec_t v;
    bit   found;
    v.data  = d;
    v.count = 0;
    found   = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (d[i]) found = 1'b1;
      if (!found) v.count++;
    end
    v.zero = (d == 32'h0);
    v.norm = v.zero ? 32'h0 : (d << v.count);
    v.lat  = v.zero ? 5 : (v.count / 8) + 2;
    return v;
  endfunction

  // Called at posedge+1 with the block idle; hold = cycles out_ready stays low in DONE.
  task automatic run_req(input vec_t e, input int hold);
    vec_t got;
    int   lat;
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_data  = e.data;
    sb.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    lat = 1;
    check("busy_after_accept", busy, 1);
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    got = sb.pop_front();
    if (!out_valid) begin
      check("out_valid_timeout", out_valid, 1);
      return;
    end
    check("latency", lat, got.lat);
    check("count", out_count, got.count);
    check("zero", out_zero, got.zero);
`ifdef CLZ_SCAN_NORM_EN
    check("norm", out_norm, got.norm);
`endif
    check("in_ready_done", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_count", out_count, got.count);
      check("hold_zero", out_zero, got.zero);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready", in_ready, 1);
    check("release_out_valid", out_valid, 0);
    check("release_busy", busy, 0);
    @(posedge clk); #1;
    check("idle_hold_count", out_count, got.count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t drop;
    tbl[0] = '{32'h8000_0000,  0, 1'b0, 32'h8000_0000, 2};
    tbl[1] = '{32'h0000_1000, 19, 1'b0, 32'h8000_0000, 4};
    tbl[2] = '{32'h0000_0000, 32, 1'b1, 32'h0000_0000, 5};
    tbl[3] = '{32'h0000_0001, 31, 1'b0, 32'h8000_0000, 5};
    tbl[4] = '{32'h00FF_0000,  8, 1'b0, 32'hFF00_0000, 3};
    tbl[5] = '{32'h4000_0000,  1, 1'b0, 32'h8000_0000, 2};
    tbl[6] = '{32'h0000_0080, 24, 1'b0, 32'h8000_0000, 5};
    tbl[7] = '{32'h0001_8000, 15, 1'b0, 32'hC000_0000, 3};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_zero", out_zero, 0);
    check("rst_busy", busy, 0);
`ifdef CLZ_SCAN_NORM_EN
    check("rst_norm", out_norm, 0);
`endif

    foreach (tbl[i]) run_req(tbl[i], 0);

    // Result held through three stalled cycles while in_valid is asserted.
    run_req(tbl[1], 3);

    for (int i = 0; i < 6; i++) begin
      run_req(mk($urandom >> $urandom_range(0, 31)), i % 2);
    end

    // Reset in the middle of a scan drops the pending result.
    in_valid = 1'b1;
    in_data  = 32'h0000_0001;
    sb.push_back(mk(32'h0000_0001));
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_scan_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", out_count, 0);
    drop = sb.pop_front();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", out_valid, 0);
    run_req(tbl[3], 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
